// File: rtl/pkg_config.sv
// -----------------------------------------------------------------------------
// pkg_config
// Shared configuration for the instruction-memory loader.
//   DATA_WIDTH       : instruction/data word width (fixed at 32)
//   LOADER_LEN_BYTES : number of little-endian bytes in the frame length field
//   loader_state_t   : loader FSM states
//   calc_word_addr() : byte address of a word index relative to a base
// -----------------------------------------------------------------------------
package pkg_config;

    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned LOADER_LEN_BYTES = 4;

    typedef enum logic [2:0] {
        LEN   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loader_state_t;

    // Word index to byte address: each word occupies four bytes.
    function automatic logic [DATA_WIDTH-1:0] calc_word_addr(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] idx
    );
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// -----------------------------------------------------------------------------
// byte_word_assembler
// Collects four bytes, least significant first, into one 32-bit word.
// The completed word is presented combinationally together with the fourth
// byte so the owner can register it on the same edge the byte is accepted.
//   i_clk        : clock
//   i_clear      : synchronous clear of the byte index and partial word
//   i_byte_stb   : a byte is accepted this cycle
//   i_byte       : the accepted byte
//   o_word       : assembled word (valid while o_word_valid is high)
//   o_word_valid : high for the cycle in which the fourth byte is accepted
// -----------------------------------------------------------------------------
module byte_word_assembler
    import pkg_config::*;
(
    input  logic                  i_clk,
    input  logic                  i_clear,
    input  logic                  i_byte_stb,
    input  logic [7:0]            i_byte,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_word_valid
);

    logic [1:0]  r_idx;
    // Only the three lower bytes need storage; the top byte is the live input.
    logic [23:0] r_low;

    assign o_word       = {i_byte, r_low};
    assign o_word_valid = i_byte_stb && (r_idx == 2'd3);

    // Byte index and partial-word shift register.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_idx <= 2'd0;
            r_low <= 24'd0;
        end else if (i_byte_stb) begin
            r_idx <= r_idx + 2'd1;
            r_low <= {i_byte, r_low[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Receives a framed byte stream (4-byte LE word count N, N LE words, one XOR
// checksum byte), writes the words sequentially into instruction memory and
// releases the core from reset once the checksum matches.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset; aborts any load in progress
//   rx_valid_i   : source presents a byte
//   rx_data_i    : stream byte
//   rx_ready_o   : loader accepts a byte (transfer = valid && ready at edge)
//   imem_we_o    : one-cycle instruction memory write strobe
//   imem_addr_o  : word-aligned byte address of the write
//   imem_data_o  : write data
//   core_rst_n_o : active-low core reset, released only after a good load
//   done_o       : load complete and verified (sticky until reset)
//   err_o        : size or checksum failure (sticky until reset)
// -----------------------------------------------------------------------------
module imem_loader
    import pkg_config::*;
#(
    parameter int unsigned           IMEM_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_ready_o,
    output logic                  imem_we_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    output logic [DATA_WIDTH-1:0] imem_data_o,
    output logic                  core_rst_n_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned WCNT_W = $clog2(IMEM_DEPTH + 1);

    loader_state_t         r_state;
    loader_state_t         w_state_next;
    logic [23:0]           r_len_low;
    logic [1:0]            r_len_cnt;
    logic [WCNT_W-1:0]     r_n;
    logic [WCNT_W-1:0]     r_widx;
    logic [WCNT_W-1:0]     w_widx_inc;
    logic [7:0]            r_csum;
    logic                  w_xfer;
    logic                  w_len_last;
    logic [31:0]           w_len_full;
    logic                  w_asm_stb;
    logic                  w_asm_clear;
    logic                  w_asm_valid;
    logic [DATA_WIDTH-1:0] w_asm_word;

    // rx_ready_o is a registered decode of the state, so it is safe to reuse.
    assign w_xfer      = rx_valid_i && rx_ready_o;
    assign w_len_full  = {rx_data_i, r_len_low};
    assign w_len_last  = (r_state == LEN) && w_xfer
                         && (r_len_cnt == 2'(LOADER_LEN_BYTES - 1));
    assign w_widx_inc  = r_widx + {{(WCNT_W-1){1'b0}}, 1'b1};
    assign w_asm_stb   = (r_state == DATA) && w_xfer;
    assign w_asm_clear = rst_i || (r_state == ERR);

    byte_word_assembler u_asm (
        .i_clk        (clk_i),
        .i_clear      (w_asm_clear),
        .i_byte_stb   (w_asm_stb),
        .i_byte       (rx_data_i),
        .o_word       (w_asm_word),
        .o_word_valid (w_asm_valid)
    );

    // Next-state decode of the loader FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LEN: begin
                if (w_len_last) begin
                    if (w_len_full > 32'(IMEM_DEPTH)) begin
                        w_state_next = ERR;
                    end else if (w_len_full == 32'd0) begin
                        w_state_next = CSUM;
                    end else begin
                        w_state_next = DATA;
                    end
                end else begin
                    w_state_next = LEN;
                end
            end
            DATA: begin
                if (w_asm_valid) begin
                    w_state_next = WRITE;
                end else begin
                    w_state_next = DATA;
                end
            end
            WRITE: begin
                if (w_widx_inc == r_n) begin
                    w_state_next = CSUM;
                end else begin
                    w_state_next = DATA;
                end
            end
            CSUM: begin
                if (w_xfer) begin
                    if (rx_data_i == r_csum) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = ERR;
                    end
                end else begin
                    w_state_next = CSUM;
                end
            end
            DONE:    w_state_next = DONE;
            ERR:     w_state_next = ERR;
            default: w_state_next = ERR;
        endcase
    end

    // State register and outputs registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= LEN;
            rx_ready_o   <= 1'b0;
            imem_we_o    <= 1'b0;
            core_rst_n_o <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            rx_ready_o   <= (w_state_next == LEN) || (w_state_next == DATA)
                            || (w_state_next == CSUM);
            imem_we_o    <= (w_state_next == WRITE);
            core_rst_n_o <= (w_state_next == DONE);
            done_o       <= (w_state_next == DONE);
            err_o        <= (w_state_next == ERR);
        end
    end

    // Length field capture (LSB first) and latched word count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_len_low <= 24'd0;
            r_len_cnt <= 2'd0;
            r_n       <= '0;
        end else if ((r_state == LEN) && w_xfer) begin
            r_len_low <= w_len_full[31:8];
            r_len_cnt <= r_len_cnt + 2'd1;
            if (w_len_last) begin
                r_n <= w_len_full[WCNT_W-1:0];
            end
        end
    end

    // Running XOR checksum of image bytes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_csum <= 8'd0;
        end else if (w_asm_stb) begin
            r_csum <= r_csum ^ rx_data_i;
        end
    end

    // Write address/data capture and word index advance after each WRITE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imem_addr_o <= BASE_ADDR;
            imem_data_o <= '0;
            r_widx      <= '0;
        end else begin
            if (w_asm_valid) begin
                imem_data_o <= w_asm_word;
                imem_addr_o <= calc_word_addr(BASE_ADDR, DATA_WIDTH'(r_widx));
            end
            if (r_state == WRITE) begin
                r_widx <= w_widx_inc;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk;
    logic        rst_i;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready_o;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_o;
    logic        core_rst_n_o;
    logic        done_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          acc_cnt;
    int          overlap_cnt;
    int          crn_high_cnt;

    imem_loader dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_ready_o   (rx_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .core_rst_n_o (core_rst_n_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Negedge monitor: captures writes, counts transfers and overlap events.
    always @(negedge clk) begin
        if (imem_we_o) begin
            wr_addr_q.push_back(imem_addr_o);
            wr_data_q.push_back(imem_data_o);
        end
        if (rx_valid && rx_ready_o && !rst_i) acc_cnt++;
        if (imem_we_o && rx_ready_o) overlap_cnt++;
        if (core_rst_n_o) crn_high_cnt++;
    end

    typedef struct {
        logic [31:0]       n;
        logic [2:0][31:0]  words;
        logic [7:0]        csum;
        logic              exp_done;
        logic              exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        acc_cnt      = 0;
        overlap_cnt  = 0;
        crn_high_cnt = 0;
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        clear_mon();
        @(posedge clk); #1;
    endtask

    // Presents one byte and waits (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit taken;
        taken = 1'b0;
        if (rnd) begin
            for (int k = 0; k < 8 && $urandom_range(1, 0) == 0; k++) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int w = 0; w < 40 && !taken; w++) begin
            @(negedge clk);
            if (rx_ready_o) begin
                @(posedge clk); #1;
                taken = 1'b1;
            end
        end
        if (!taken) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout actual=ready_low required=accept byte=%h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] cs;
        int         base_acc;

        rst_i    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        acc_cnt = 0; overlap_cnt = 0; crn_high_cnt = 0;

        // Directed frames; checksum is the XOR of every image byte.
        vecs[0] = '{32'd2, {32'h0, 32'h0010_0113, 32'h0000_0093}, 8'h91, 1'b1, 1'b0};
        vecs[1] = '{32'd0, {32'h0, 32'h0, 32'h0},                 8'h00, 1'b1, 1'b0};
        vecs[2] = '{32'd0, {32'h0, 32'h0, 32'h0},                 8'h01, 1'b0, 1'b1};
        vecs[3] = '{32'd2, {32'h0, 32'h0010_0113, 32'h0000_0093}, 8'h92, 1'b0, 1'b1};
        vecs[4] = '{32'd1, {32'h0, 32'h0, 32'hDEAD_BEEF},         8'h22, 1'b1, 1'b0};
        vecs[5] = '{32'd3, {32'h99AA_BBCC, 32'h5566_7788, 32'h1122_3344}, 8'hCC, 1'b1, 1'b0};

        // Reset values.
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, rx_ready_o}, 32'd0);
        chk("rst_we", {31'd0, imem_we_o}, 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0000_0000);
        chk("rst_data", imem_data_o, 32'd0);
        chk("rst_core_n", {31'd0, core_rst_n_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        rst_i = 1'b0;
        chk("ready_before_edge", {31'd0, rx_ready_o}, 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", {31'd0, rx_ready_o}, 32'd1);

        // Table-driven frames with rx_valid held high.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            send_word(vecs[v].n, 1'b0);
            for (int i = 0; i < 32'(vecs[v].n); i++) send_word(vecs[v].words[i], 1'b0);
            send_byte(vecs[v].csum, 1'b0);
            rx_valid = 1'b0;
            chk($sformatf("v%0d_done", v), {31'd0, done_o}, {31'd0, vecs[v].exp_done});
            chk($sformatf("v%0d_err", v), {31'd0, err_o}, {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_core_n", v), {31'd0, core_rst_n_o}, {31'd0, vecs[v].exp_done});
            idle(4);
            chk($sformatf("v%0d_done_hold", v), {31'd0, done_o}, {31'd0, vecs[v].exp_done});
            chk($sformatf("v%0d_err_hold", v), {31'd0, err_o}, {31'd0, vecs[v].exp_err});
            chk($sformatf("v%0d_ready_low", v), {31'd0, rx_ready_o}, 32'd0);
            chk($sformatf("v%0d_wr_count", v), 32'(wr_addr_q.size()), vecs[v].n);
            for (int i = 0; i < wr_addr_q.size() && i < 3; i++) begin
                chk($sformatf("v%0d_wr%0d_addr", v, i), wr_addr_q[i], 32'(4 * i));
                chk($sformatf("v%0d_wr%0d_data", v, i), wr_data_q[i], vecs[v].words[i]);
            end
            chk($sformatf("v%0d_ready_we_overlap", v), 32'(overlap_cnt), 32'd0);
        end

        // Oversize length: error right after the fourth length byte.
        do_reset();
        send_word(32'd257, 1'b0);
        chk("big_err", {31'd0, err_o}, 32'd1);
        chk("big_ready", {31'd0, rx_ready_o}, 32'd0);
        base_acc = acc_cnt;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        chk("big_no_accept", 32'(acc_cnt - base_acc), 32'd0);
        chk("big_no_writes", 32'(wr_addr_q.size()), 32'd0);
        chk("big_core_n", {31'd0, core_rst_n_o}, 32'd0);

        // Full-depth image: word i = i, so the byte XOR of 0..255 is 0.
        do_reset();
        send_word(32'd256, 1'b0);
        for (int i = 0; i < 256; i++) send_word(32'(i), 1'b0);
        send_byte(8'h00, 1'b0);
        rx_valid = 1'b0;
        idle(2);
        chk("full_done", {31'd0, done_o}, 32'd1);
        chk("full_wr_count", 32'(wr_addr_q.size()), 32'd256);
        if (wr_addr_q.size() == 256) begin
            chk("full_last_addr", wr_addr_q[255], 32'h0000_03FC);
            chk("full_last_data", wr_data_q[255], 32'd255);
            chk("full_mid_addr", wr_addr_q[128], 32'h0000_0200);
        end

        // Random valid gaps: exactly 4+4+1 bytes consumed.
        do_reset();
        send_word(32'd1, 1'b1);
        send_word(32'hCAFE_F00D, 1'b1);
        send_byte(8'hC9, 1'b1);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        chk("rnd_done", {31'd0, done_o}, 32'd1);
        chk("rnd_accepted", 32'(acc_cnt), 32'd9);
        chk("rnd_wr_count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            chk("rnd_addr", wr_addr_q[0], 32'h0000_0000);
            chk("rnd_data", wr_data_q[0], 32'hCAFE_F00D);
        end
        chk("rnd_overlap", 32'(overlap_cnt), 32'd0);

        // Abort mid-frame with a byte offered at the reset edge, then reload.
        do_reset();
        send_word(32'd3, 1'b0);
        send_word(32'hA1B2_C3D4, 1'b0);
        send_byte(8'hE5, 1'b0);
        send_byte(8'hF6, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        rst_i    = 1'b1;
        @(posedge clk); #1;
        chk("abort_core_n", {31'd0, core_rst_n_o}, 32'd0);
        chk("abort_ready", {31'd0, rx_ready_o}, 32'd0);
        chk("abort_addr", imem_addr_o, 32'h0000_0000);
        rst_i    = 1'b0;
        rx_valid = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
        cs = 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78;
        send_word(32'd1, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_byte(cs, 1'b0);
        rx_valid = 1'b0;
        idle(2);
        chk("reload_done", {31'd0, done_o}, 32'd1);
        chk("reload_err", {31'd0, err_o}, 32'd0);
        chk("reload_wr_count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            chk("reload_addr", wr_addr_q[0], 32'h0000_0000);
            chk("reload_data", wr_data_q[0], 32'h1234_5678);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
